// File: rtl/ssp_xcvr_if.sv
// rtl/ssp_xcvr_if.sv - FIFO-side handshake bundle for the SSP transceiver
interface ssp_xcvr_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  rx_ready;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;

    // FIFO side: offers TX words and accepts RX words
    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    // Transceiver side
    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/ssp_xcvr.sv
// rtl/ssp_xcvr.sv - synchronous serial port transceiver (frame-sync, word-serial TX/RX)
module ssp_xcvr #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic      pclk,
    input  logic      clear,
    ssp_xcvr_if.slave fifo,
    input  logic      err_clr,
    input  logic      loopback,
    output logic      rx_overrun,
    output logic      frame_err,
    output logic      sspclkout,
    output logic      sspfssout,
    output logic      ssptxd,
    output logic      sspoe_b,
    input  logic      sspclkin,
    input  logic      sspfssin,
    input  logic      ssprxd
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    // ---------------- serial clock divider ----------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sspclkout_q;
    logic          period_end;

    assign cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    assign period_end = (cnt_q == CNT_LAST);

    // Free-running period counter; sspclkout is high for the first half period
    always_ff @(posedge pclk) begin
        if (clear) begin
            cnt_q       <= CNT_LAST;
            sspclkout_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sspclkout_q <= (cnt_d < CNT_HALF);
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {T_IDLE, T_FRAME, T_SHIFT} tx_state_t;

    tx_state_t             tx_state_q, tx_state_d;
    logic [BW-1:0]         tb_q, tb_d;
    logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;
    logic                  fss_q, txd_q, txd_d, oe_b_q, oe_b_d;
    logic                  tx_pop;

    // A word is taken only at a word boundary: idle, or the last cycle of the last bit
    assign tx_pop = !clear && fifo.tx_valid && period_end &&
                    ((tx_state_q == T_IDLE) ||
                     (tx_state_q == T_SHIFT && tb_q == BIT_LAST));
    assign fifo.tx_ready = tx_pop;

    // TX next state; the word shifts so the outgoing bit always sits at one end
    always_comb begin
        tx_state_d = tx_state_q;
        tb_d       = tb_q;
        tx_word_d  = tx_word_q;
        if (tx_pop) begin
            tx_state_d = T_FRAME;
            tb_d       = '0;
            tx_word_d  = fifo.tx_data;
        end else if (period_end) begin
            case (tx_state_q)
                T_FRAME: begin
                    tx_state_d = T_SHIFT;
                    tb_d       = '0;
                end
                T_SHIFT: begin
                    if (tb_q == BIT_LAST) begin
                        tx_state_d = T_IDLE;
                    end else begin
                        tb_d      = tb_q + 1'b1;
                        tx_word_d = (MSB_FIRST != 0) ? (tx_word_q << 1) : (tx_word_q >> 1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line output decode from next state so the registered pins line up with the state
    always_comb begin
        oe_b_d = oe_b_q;
        if (tx_state_d == T_IDLE)
            oe_b_d = 1'b1;
        else if (tx_state_d == T_FRAME && cnt_d == CNT_HALF)
            oe_b_d = 1'b0;
        txd_d = 1'b0;
        if (tx_state_d == T_SHIFT)
            txd_d = (MSB_FIRST != 0) ? tx_word_d[DATA_WIDTH-1] : tx_word_d[0];
    end

    // TX FSM state and registered line outputs
    always_ff @(posedge pclk) begin
        if (clear) begin
            tx_state_q <= T_IDLE;
            tb_q       <= '0;
            tx_word_q  <= '0;
            fss_q      <= 1'b0;
            txd_q      <= 1'b0;
            oe_b_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tb_q       <= tb_d;
            tx_word_q  <= tx_word_d;
            fss_q      <= (tx_state_d == T_FRAME);
            txd_q      <= txd_d;
            oe_b_q     <= oe_b_d;
        end
    end

    assign sspclkout = sspclkout_q;
    assign sspfssout = fss_q;
    assign ssptxd    = txd_q;
    assign sspoe_b   = oe_b_q;

    // ---------------- receiver ----------------
    logic       rclk_src, rfss_src, rdat_src;
    logic [1:0] rclk_sync_q, rfss_sync_q, rdat_sync_q;
    logic       rclk_prev_q;
    logic       rxedge, rx_fss, rx_bit;

    assign rclk_src = loopback ? sspclkout_q : sspclkin;
    assign rfss_src = loopback ? fss_q       : sspfssin;
    assign rdat_src = loopback ? txd_q       : ssprxd;

    // Two-flop synchronizers; clock, frame and data share the same latency
    always_ff @(posedge pclk) begin
        if (clear) begin
            rclk_sync_q <= '0;
            rfss_sync_q <= '0;
            rdat_sync_q <= '0;
            rclk_prev_q <= 1'b0;
        end else begin
            rclk_sync_q <= {rclk_sync_q[0], rclk_src};
            rfss_sync_q <= {rfss_sync_q[0], rfss_src};
            rdat_sync_q <= {rdat_sync_q[0], rdat_src};
            rclk_prev_q <= rclk_sync_q[1];
        end
    end

    assign rxedge = rclk_sync_q[1] & ~rclk_prev_q;
    assign rx_fss = rfss_sync_q[1];
    assign rx_bit = rdat_sync_q[1];

    typedef enum logic {R_IDLE, R_DATA} rx_state_t;

    rx_state_t             rx_state_q;
    logic [BW-1:0]         rb_q;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q;
    logic                  rx_valid_q, overrun_q, frame_err_q;
    logic                  ovr_set, ferr_set;

    assign rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], rx_bit}
                                         : {rx_bit, rx_shift_q[DATA_WIDTH-1:1]};
    assign ferr_set = rxedge && (rx_state_q == R_DATA) && rx_fss;
    assign ovr_set  = rxedge && (rx_state_q == R_DATA) && !rx_fss &&
                      (rb_q == BIT_LAST) && !fifo.rx_ready;

    // RX FSM: frame on fss edge, shift bits, push or drop the completed word
    always_ff @(posedge pclk) begin
        if (clear) begin
            rx_state_q  <= R_IDLE;
            rb_q        <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rxedge) begin
                case (rx_state_q)
                    R_IDLE: begin
                        if (rx_fss) begin
                            rx_state_q <= R_DATA;
                            rb_q       <= '0;
                        end
                    end
                    R_DATA: begin
                        if (rx_fss) begin
                            rb_q       <= '0;
                            rx_shift_q <= '0;
                        end else begin
                            rx_shift_q <= rx_shift_d;
                            if (rb_q == BIT_LAST) begin
                                rx_state_q <= R_IDLE;
                                rb_q       <= '0;
                                if (fifo.rx_ready) begin
                                    rx_valid_q <= 1'b1;
                                    rx_data_q  <= rx_shift_d;
                                end
                            end else begin
                                rb_q <= rb_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            overrun_q   <= ovr_set  | (overrun_q   & ~err_clr);
            frame_err_q <= ferr_set | (frame_err_q & ~err_clr);
        end
    end

    assign fifo.rx_valid = rx_valid_q;
    assign fifo.rx_data  = rx_data_q;
    assign rx_overrun    = overrun_q;
    assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_ssp_xcvr.sv
// tb/tb_ssp_xcvr.sv - scoreboard testbench for ssp_xcvr
module tb_ssp_xcvr;
    localparam int W = 8;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic clear, err_clr, loopback, sspclkin, sspfssin, ssprxd;
    logic rx_overrun, frame_err, sspclkout, sspfssout, ssptxd, sspoe_b;
    logic rx_overrun_l, frame_err_l, sspclkout_l, sspfssout_l, ssptxd_l, sspoe_b_l;

    ssp_xcvr_if #(.DATA_WIDTH(W)) bus ();
    ssp_xcvr_if #(.DATA_WIDTH(W)) bus_l ();

    ssp_xcvr #(.DATA_WIDTH(W), .CLK_DIV(4), .MSB_FIRST(1)) dut (
        .pclk(pclk), .clear(clear), .fifo(bus), .err_clr(err_clr), .loopback(loopback),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .sspclkout(sspclkout),
        .sspfssout(sspfssout), .ssptxd(ssptxd), .sspoe_b(sspoe_b),
        .sspclkin(sspclkin), .sspfssin(sspfssin), .ssprxd(ssprxd)
    );

    ssp_xcvr #(.DATA_WIDTH(W), .CLK_DIV(4), .MSB_FIRST(0)) dut_l (
        .pclk(pclk), .clear(clear), .fifo(bus_l), .err_clr(1'b0), .loopback(1'b1),
        .rx_overrun(rx_overrun_l), .frame_err(frame_err_l), .sspclkout(sspclkout_l),
        .sspfssout(sspfssout_l), .ssptxd(ssptxd_l), .sspoe_b(sspoe_b_l),
        .sspclkin(1'b0), .sspfssin(1'b0), .ssprxd(1'b0)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] txq[$];
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] exp_line[$];
    logic [W-1:0] exp_rx_l[$];
    logic [W-1:0] exp_line_l[$];
    int           exp_oe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // TX FIFO model: strobe seen mid-cycle, word removed just after the latching edge
    initial begin
        bit take;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        forever begin
            @(negedge pclk);
            take = (bus.tx_ready === 1'b1);
            if (take) pops++;
            @(posedge pclk);
            #1;
            if (take && txq.size() > 0) void'(txq.pop_front());
            bus.tx_valid = (txq.size() > 0);
            bus.tx_data  = (txq.size() > 0) ? txq[0] : '0;
        end
    end

    // Monitor for the MSB-first DUT: RX pushes, TX line decode, frame and enable timing
    bit           prev_clk = 1'b0, prev_rxv = 1'b0, lcol = 1'b0;
    int           lcnt = 0, fss_run = 0, oe_run = 0;
    logic [W-1:0] lword = '0;
    always @(negedge pclk) begin
        if (mon_en) begin
            if (bus.rx_valid === 1'b1) begin
                check("rx_valid_single", prev_rxv, 0);
                check("rx_push_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) check("rx_data", bus.rx_data, exp_rx.pop_front());
            end
            if (sspfssout === 1'b1) begin
                fss_run++;
                check("txd_zero_in_frame", ssptxd, 0);
            end else if (fss_run > 0) begin
                if (!clear) check("fss_len", fss_run, 4);
                fss_run = 0;
            end
            if (sspoe_b === 1'b0) begin
                oe_run++;
            end else if (oe_run > 0) begin
                if (!clear) begin
                    check("oe_run_expected", exp_oe.size() != 0, 1);
                    if (exp_oe.size() != 0) check("oe_low_run", oe_run, exp_oe.pop_front());
                end
                oe_run = 0;
            end
            if (clear) lcol = 1'b0;
            if (sspclkout && !prev_clk) begin
                if (sspfssout) begin
                    lcnt = 0;
                    lcol = 1'b1;
                end else if (lcol) begin
                    lword = {lword[W-2:0], ssptxd};
                    lcnt++;
                    if (lcnt == W) begin
                        lcol = 1'b0;
                        check("line_expected", exp_line.size() != 0, 1);
                        if (exp_line.size() != 0) check("line_word", lword, exp_line.pop_front());
                    end
                end else begin
                    check("txd_idle", ssptxd, 0);
                end
            end
            prev_rxv = bus.rx_valid;
            prev_clk = sspclkout;
        end
    end

    // Monitor for the LSB-first DUT: bit k of the decoded vector is shift period k
    bit           prev_clk_l = 1'b0, lcol_l = 1'b0;
    int           lcnt_l = 0;
    logic [W-1:0] lword_l = '0;
    always @(negedge pclk) begin
        if (mon_en) begin
            if (bus_l.rx_valid === 1'b1) begin
                check("lsb_rx_expected", exp_rx_l.size() != 0, 1);
                if (exp_rx_l.size() != 0) check("lsb_rx_data", bus_l.rx_data, exp_rx_l.pop_front());
            end
            if (sspclkout_l && !prev_clk_l) begin
                if (sspfssout_l) begin
                    lcnt_l = 0;
                    lcol_l = 1'b1;
                end else if (lcol_l) begin
                    lword_l[lcnt_l] = ssptxd_l;
                    lcnt_l++;
                    if (lcnt_l == W) begin
                        lcol_l = 1'b0;
                        check("lsb_line_expected", exp_line_l.size() != 0, 1);
                        if (exp_line_l.size() != 0) check("lsb_line_bits", lword_l, exp_line_l.pop_front());
                    end
                end
            end
            prev_clk_l = sspclkout_l;
        end
    end

    task automatic pin_period(input logic fss, input logic d);
        sspfssin = fss;
        ssprxd   = d;
        sspclkin = 1'b1;
        repeat (4) @(negedge pclk);
        sspclkin = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic check_drained(input string name);
        check({name, "_rx_drained"}, exp_rx.size(), 0);
        check({name, "_line_drained"}, exp_line.size(), 0);
        check({name, "_oe_drained"}, exp_oe.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_sspclkout"}, sspclkout, 0);
        check({name, "_sspfssout"}, sspfssout, 0);
        check({name, "_ssptxd"}, ssptxd, 0);
        check({name, "_sspoe_b"}, sspoe_b, 1);
        check({name, "_tx_ready"}, bus.tx_ready, 0);
        check({name, "_rx_valid"}, bus.rx_valid, 0);
        check({name, "_rx_data"}, bus.rx_data, 0);
        check({name, "_rx_overrun"}, rx_overrun, 0);
        check({name, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        bit seen;
        clear = 1'b1; err_clr = 1'b0; loopback = 1'b1;
        sspclkin = 1'b0; sspfssin = 1'b0; ssprxd = 1'b0;
        bus.rx_ready   = 1'b1;
        bus_l.rx_ready = 1'b1;
        bus_l.tx_valid = 1'b0;
        bus_l.tx_data  = '0;
        wait_cycles(3);
        check_reset_outputs("rst");
        clear = 1'b0;
        @(negedge pclk);
        check("release_sspclkout", sspclkout, 1);
        mon_en = 1'b1;

        // single word in loopback
        txq.push_back(8'hA5); exp_line.push_back(8'hA5); exp_rx.push_back(8'hA5); exp_oe.push_back(34);
        wait_cycles(60);
        check("s1_pops", pops, 1);
        check_drained("s1");

        // two queued words, back to back
        txq.push_back(8'h3C); txq.push_back(8'hC3);
        exp_line.push_back(8'h3C); exp_line.push_back(8'hC3);
        exp_rx.push_back(8'h3C); exp_rx.push_back(8'hC3);
        exp_oe.push_back(70);
        wait_cycles(100);
        check("s2_pops", pops, 3);
        check_drained("s2");

        // LSB-first instance
        bus_l.tx_valid = 1'b1;
        bus_l.tx_data  = 8'h01;
        exp_line_l.push_back(8'h01);
        exp_rx_l.push_back(8'h01);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclk);
            if (bus_l.tx_ready === 1'b1) seen = 1'b1;
        end
        check("lsb_pop_seen", seen, 1);
        @(posedge pclk);
        #1;
        bus_l.tx_valid = 1'b0;
        wait_cycles(60);
        check("lsb_line_drained", exp_line_l.size(), 0);
        check("lsb_rx_drained", exp_rx_l.size(), 0);

        // overrun with RX FIFO full
        bus.rx_ready = 1'b0;
        txq.push_back(8'h55); exp_line.push_back(8'h55); exp_oe.push_back(34);
        wait_cycles(60);
        check("ovr_set", rx_overrun, 1);
        check("ovr_no_frame_err", frame_err, 0);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        check("ovr_cleared", rx_overrun, 0);
        bus.rx_ready = 1'b1;
        check("s4_pops", pops, 4);
        check_drained("s4");

        // frame sync mid-word on the external pins, then a clean 0x0F
        loopback = 1'b0;
        wait_cycles(4);
        exp_rx.push_back(8'h0F);
        pin_period(1'b1, 1'b0);
        pin_period(1'b0, 1'b1);
        pin_period(1'b0, 1'b0);
        pin_period(1'b0, 1'b1);
        pin_period(1'b1, 1'b0);
        for (int i = 0; i < W; i++) pin_period(1'b0, (i >= 4) ? 1'b1 : 1'b0);
        check("ferr_set", frame_err, 1);
        check("ferr_no_overrun", rx_overrun, 0);
        check("s5_rx_drained", exp_rx.size(), 0);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        check("ferr_cleared", frame_err, 0);
        loopback = 1'b1;
        wait_cycles(4);

        // clear during shift period 4
        txq.push_back(8'h96);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge pclk);
            if (sspfssout === 1'b1) seen = 1'b1;
        end
        check("s6_frame_seen", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclk);
            if (sspfssout === 1'b0) seen = 1'b1;
        end
        check("s6_shift_seen", seen, 1);
        wait_cycles(17);
        clear = 1'b1;
        @(negedge pclk);
        check_reset_outputs("clr");
        wait_cycles(2);
        clear = 1'b0;
        wait_cycles(80);
        check("s6_pops", pops, 5);
        check_drained("s6");

        // recovery word after the abort
        txq.push_back(8'h5A); exp_line.push_back(8'h5A); exp_rx.push_back(8'h5A); exp_oe.push_back(34);
        wait_cycles(60);
        check("s7_pops", pops, 6);
        check_drained("s7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
